// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: slice op codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/ALU1Bit.sv
// One-bit ALU slice: op[2] inverts b, op[1:0] selects AND / OR / SUM / less.
module ALU1Bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       less,
  input  logic [2:0] op,
  output logic       result,
  output logic       cout,
  output logic       set,
  output logic       g,
  output logic       p
);

  logic b_eff;
  logic sum;

  always_comb begin
    b_eff = b ^ op[2];
    sum   = a ^ b_eff ^ cin;
    cout  = (a & b_eff) | (a & cin) | (b_eff & cin);
    g     = a & b_eff;
    p     = a | b_eff;
    set   = sum;
    case (op[1:0])
      2'b00:   result = a & b_eff;
      2'b01:   result = a | b_eff;
      2'b10:   result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU driving one ALU1Bit slice LSB first, with SLT fix-up.
// Optional completed-operation counter enabled by ALU_SEQ_OP_COUNT_EN.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             set_msb_q, set_msb_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic slice_res;
  logic slice_cout;
  logic slice_set;

  // less is tied low, so every RUN bit of an SLT is 0 until FIX patches bit 0.
  ALU1Bit u_slice (
    .a      (a_q[idx_q]),
    .b      (b_q[idx_q]),
    .cin    (carry_q),
    .less   (1'b0),
    .op     (op_q),
    .result (slice_res),
    .cout   (slice_cout),
    .set    (slice_set),
    .g      (),
    .p      ()
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    set_msb_d  = set_msb_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = op[2];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[idx_q] = slice_res;
        carry_d         = slice_cout;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          set_msb_d = slice_set;
          ovf_d     = carry_q ^ slice_cout;
          idx_d     = '0;
          state_d   = (op_q[1:0] == OP_SLT[1:0]) ? S_FIX : S_DONE;
        end
      end
      S_FIX: begin
        result_d[0] = set_msb_q ^ ovf_q;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flags are registered on entry to DONE so they are valid with the pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      zero_d     = (result_d == '0);
      overflow_d = op_q[1] ? ovf_d : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      set_msb_q  <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      set_msb_q  <= set_msb_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

`ifdef ALU_SEQ_OP_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DONE) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign op_count = cnt_q;
`else
  assign op_count = '0;
`endif

endmodule
